id_hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed one-bubble load-use detector in the decode stage.
- Tracks, per architectural register, how many cycles remain until an in-flight producer's result can be forwarded.
- Raises stall for RAW hazards with any producer latency (ALU, load, multi-cycle multiply) and for WAW ordering hazards.
- Sits in the ID stage. Its stall drives PC/IF write-enable and ID/EX bubble insertion.

---
 rtl/id_hazard_scoreboard_pkg.sv | 21 ++
 rtl/id_hazard_scoreboard_lat_counter.sv | 43 ++++
 rtl/id_hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_scoreboard_pkg
// Purpose  : Shared constants for the ID-stage hazard scoreboard: producer
//            latency classes and the default register-file geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package id_hazard_scoreboard_pkg;

    // Cycles from leaving ID until the result is reachable by forwarding.
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;

    // Default architectural register file geometry.
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;

endpackage : id_hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/id_hazard_scoreboard_lat_counter.sv
`default_nettype none
// ============================================================================
// Module   : hazard_lat_counter
// Purpose  : Per-register countdown of cycles remaining until the in-flight
//            producer of that register becomes forwardable.
// Ports    : clk        - rising-edge clock
//            rst_n      - synchronous active-low reset (clears the count)
//            i_load     - accepted issue targets this register
//            i_loadVal  - latency to load (already saturated by the caller)
//            o_cnt      - current remaining-cycle count
//            o_busy     - count is nonzero
// Revision : 1.0 - initial release
// ============================================================================
module hazard_lat_counter #(
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [LATW-1:0] i_loadVal,
    output logic [LATW-1:0] o_cnt,
    output logic            o_busy
);

    logic [LATW-1:0] r_cnt;

    // A new issue overwrites any count still running down; otherwise the
    // count decays by one per cycle and parks at zero, so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_loadVal;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LATW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = (r_cnt != '0);

endmodule : hazard_lat_counter
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_scoreboard
// Purpose  : ID-stage scoreboard. Tracks, per architectural register, the
//            cycles left until its pending producer can be forwarded, and
//            raises stall for RAW hazards (any producer latency) and for WAW
//            ordering hazards.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            issue_valid/we      - ID instruction valid / writes a register
//            issue_dst/lat       - destination register and producer latency
//            src_valid/src_addr  - per-source read enable and address
//            flush               - kill the ID instruction
//            stall               - hold PC/IF/ID, bubble into EX
//            busy_mask           - registers with a nonzero count
//            pending_count       - population count of busy_mask
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int AW     = DEF_AW,
    parameter int NSRC   = 2,
    parameter int MAXLAT = LAT_MUL,
    parameter int LATW   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic                       issue_we,
    input  logic [AW-1:0]              issue_dst,
    input  logic [LATW-1:0]            issue_lat,
    input  logic [NSRC-1:0]            src_valid,
    input  logic [NSRC*AW-1:0]         src_addr,
    input  logic                       flush,
    output logic                       stall,
    output logic [NREG-1:0]            busy_mask,
    output logic [$clog2(NREG+1)-1:0]  pending_count
);

    localparam int              c_PCW    = $clog2(NREG+1);
    localparam logic [LATW-1:0] c_MAXLAT = LATW'(MAXLAT);
    // Count of 1 is covered by the EX/MEM forwarding path; only 2+ stalls.
    localparam logic [LATW-1:0] c_STALL_MIN = LATW'(2);

    logic [LATW-1:0] w_cnt [NREG];
    logic [LATW-1:0] w_latEff;
    logic            w_raw;
    logic            w_waw;
    logic            w_accept;

    assign w_latEff = (issue_lat > c_MAXLAT) ? c_MAXLAT : issue_lat;

    // Register 0 is hardwired zero and never produces a hazard.
    assign w_cnt[0]     = '0;
    assign busy_mask[0] = 1'b0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_cnt
            hazard_lat_counter #(
                .LATW (LATW)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_load    (w_accept && (issue_dst == AW'(r))),
                .i_loadVal (w_latEff),
                .o_cnt     (w_cnt[r]),
                .o_busy    (busy_mask[r])
            );
        end
    endgenerate

    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i] && (src_addr[i*AW +: AW] != '0) &&
                (w_cnt[src_addr[i*AW +: AW]] >= c_STALL_MIN)) begin
                w_raw = 1'b1;
            end
        end
    end

    // A younger write must not land before an older, slower one to the same
    // register completes.
    assign w_waw = issue_valid && issue_we && (issue_dst != '0) &&
                   (w_cnt[issue_dst] > w_latEff);

    assign stall = !flush && issue_valid && (w_raw || w_waw);

    // Zero-latency writes are accepted by the pipeline but need no tracking.
    assign w_accept = issue_valid && !stall && !flush && issue_we &&
                      (issue_dst != '0) && (w_latEff != '0);

    always_comb begin
        pending_count = '0;
        for (int r = 0; r < NREG; r++) begin
            pending_count = pending_count + c_PCW'(busy_mask[r]);
        end
    end

endmodule : id_hazard_scoreboard
`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_scoreboard
// Purpose  : Self-checking bench for id_hazard_scoreboard. A reference model
//            keeps, per register, the absolute cycle at which its producer
//            becomes forwardable; every cycle the DUT outputs are compared
//            to it, and directed scenarios pin literal expectations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int NSRC   = 2;
    localparam int MAXLAT = 4;
    localparam int LATW   = 3;
    localparam int PCW    = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic                 issue_we;
    logic [AW-1:0]        issue_dst;
    logic [LATW-1:0]      issue_lat;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*AW-1:0]   src_addr;
    logic                 flush;
    logic                 stall;
    logic [NREG-1:0]      busy_mask;
    logic [PCW-1:0]       pending_count;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(
        .NREG   (NREG),
        .AW     (AW),
        .NSRC   (NSRC),
        .MAXLAT (MAXLAT),
        .LATW   (LATW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_dst     (issue_dst),
        .issue_lat     (issue_lat),
        .src_valid     (src_valid),
        .src_addr      (src_addr),
        .flush         (flush),
        .stall         (stall),
        .busy_mask     (busy_mask),
        .pending_count (pending_count)
    );

    // ---------------- reference model ----------------
    int cyc = 0;
    int readyAt [NREG];
    bit modelValid = 1'b0;

    function automatic int remaining(int r);
        if (r == 0) return 0;
        return (readyAt[r] > cyc) ? readyAt[r] - cyc : 0;
    endfunction

    function automatic int effLat();
        return (int'(issue_lat) > MAXLAT) ? MAXLAT : int'(issue_lat);
    endfunction

    function automatic bit modelStall();
        bit hz = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (src_valid[i] && remaining(int'(src_addr[i*AW +: AW])) >= 2) hz = 1'b1;
        if (issue_we && issue_dst != 0 && remaining(int'(issue_dst)) > effLat()) hz = 1'b1;
        return !flush && issue_valid && hz;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) readyAt[r] = 0;
            modelValid = 1'b1;
        end else if (issue_valid && !flush && !modelStall() && issue_we &&
                     issue_dst != 0 && effLat() != 0) begin
            readyAt[issue_dst] = cyc + 1 + effLat();
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            logic [NREG-1:0] expMask;
            int expCnt;
            expMask = '0;
            expCnt  = 0;
            for (int r = 1; r < NREG; r++) begin
                if (remaining(r) != 0) begin
                    expMask[r] = 1'b1;
                    expCnt++;
                end
            end
            chk("model_stall", int'(stall), int'(modelStall()));
            nChecks++;
            if (busy_mask !== expMask) begin
                nFails++;
                $display("FAIL model_busy_mask: got %h expected %h (t=%0t)", busy_mask, expMask, $time);
            end
            chk("model_pending", int'(pending_count), expCnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit we, input int dst, input int lat,
                         input bit s0v, input int s0, input bit s1v, input int s1,
                         input bit fl);
        issue_valid = v;
        issue_we    = we;
        issue_dst   = AW'(dst);
        issue_lat   = LATW'(lat);
        src_valid   = {s1v, s0v};
        src_addr    = {AW'(s1), AW'(s0)};
        flush       = fl;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 5, 2, 0, 0, 0, 0, 0);
        #1;

        // Reset held two cycles with a live issue present.
        tick();
        chk("rst_busy", int'(busy_mask), 0);
        chk("rst_stall", int'(stall), 0);
        tick();
        chk("rst_pending", int'(pending_count), 0);
        rst_n = 1'b1;
        idle();
        chk("rst_release_busy", int'(busy_mask), 0);
        tick();
        chk("rst_release_pending", int'(pending_count), 0);

        // Load-use: exactly one stall cycle.
        drive(1, 1, 8, 2, 0, 0, 0, 0, 0);
        chk("lu_issue_stall", int'(stall), 0);
        tick();
        drive(1, 0, 0, 0, 1, 8, 0, 0, 0);
        chk("lu_t1_stall", int'(stall), 1);
        chk("lu_t1_busy8", int'(busy_mask[8]), 1);
        tick();
        chk("lu_t2_stall", int'(stall), 0);
        chk("lu_t2_busy8", int'(busy_mask[8]), 1);
        tick();
        idle();
        chk("lu_t3_busy8", int'(busy_mask[8]), 0);
        tick();

        // ALU chain: forwardable next cycle, no stall.
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 9, 0);
        chk("alu_stall", int'(stall), 0);
        chk("alu_busy9", int'(busy_mask[9]), 1);
        tick();
        idle();
        chk("alu_busy9_gone", int'(busy_mask[9]), 0);
        tick();

        // Multi-cycle producer: three stall cycles.
        drive(1, 1, 10, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 10, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("mul_stall", int'(stall), (k < 3) ? 1 : 0);
            chk("mul_pending", int'(pending_count), 1);
            tick();
        end
        idle();
        chk("mul_pending_end", int'(pending_count), 0);
        tick();

        // WAW: slower older write must finish first.
        drive(1, 1, 11, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 11, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("waw_stall", int'(stall), (k < 3) ? 1 : 0);
            tick();
        end
        idle();
        chk("waw_busy11", int'(busy_mask[11]), 1);
        chk("waw_pending", int'(pending_count), 1);
        tick();
        chk("waw_busy11_gone", int'(busy_mask[11]), 0);

        // Register 0 is never tracked.
        drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
        tick();
        idle();
        chk("r0_busy", int'(busy_mask), 0);

        // Flush: no stall, no load, pending counters untouched.
        drive(1, 1, 12, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 13, 3, 1, 12, 0, 0, 1);
        chk("flush_stall", int'(stall), 0);
        tick();
        idle();
        chk("flush_busy13", int'(busy_mask[13]), 0);
        chk("flush_busy12", int'(busy_mask[12]), 1);
        tick();
        tick();
        tick();

        // Saturation: lat=7 behaves as MAXLAT=4.
        drive(1, 1, 14, 7, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            chk("sat_busy14", int'(busy_mask[14]), (k < 4) ? 1 : 0);
            tick();
        end

        // Both sources checked: second source alone triggers stall.
        drive(1, 1, 16, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 7, 1, 16, 0);
        chk("src1_stall", int'(stall), 1);
        tick();

        // Mid-count reset discards everything.
        drive(1, 1, 15, 4, 0, 0, 0, 0, 0);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", int'(busy_mask), 0);
        chk("midrst_pending", int'(pending_count), 0);
        rst_n = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule : tb_id_hazard_scoreboard
`default_nettype wire
